// File: rtl/timeout_timer_pkg.sv
// Shared definitions for the enable-gated timeout timer and its users
// in the Ethernet receive path.
package timeout_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  localparam int TIMER_WIDTH_DEFAULT = 10;

  // Protocol-field wait used by the MAC receiver after an address match.
  localparam int RX_PROTO_TIMEOUT_TC = (2 ** TIMER_WIDTH_DEFAULT) - 1;

endpackage

// File: rtl/timeout_timer.sv
// Auto-reloading timeout counter with a registered one-cycle expiry pulse.
// Define TIMEOUT_TIMER_STATUS_EN to expose count_out and running.
module timeout_timer
  import timeout_timer_pkg::*;
#(
  parameter int TIMER_WIDTH    = TIMER_WIDTH_DEFAULT,
  parameter int TERMINAL_COUNT = (2 ** TIMER_WIDTH) - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   timer_out
`ifdef TIMEOUT_TIMER_STATUS_EN
  ,
  output logic [TIMER_WIDTH-1:0] count_out,
  output logic                   running
`endif
);

  generate
    if (TERMINAL_COUNT < 1 || TERMINAL_COUNT > (2 ** TIMER_WIDTH) - 1) begin : g_bad_terminal
      $error("timeout_timer: TERMINAL_COUNT out of range 1..2**TIMER_WIDTH-1");
    end
  endgenerate

  localparam logic [TIMER_WIDTH-1:0] TC  = TIMER_WIDTH'(TERMINAL_COUNT);
  localparam logic [TIMER_WIDTH-1:0] ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  timer_state_t           state, state_next;
  logic [TIMER_WIDTH-1:0] cnt, cnt_next;
  logic                   timer_out_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      timer_out <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      timer_out <= timer_out_next;
    end
  end

  // Expiry is an event inside RUN: wrap to zero and pulse, no extra state.
  always_comb begin
    state_next     = state;
    cnt_next       = '0;
    timer_out_next = 1'b0;

    case (state)
      IDLE:    if (enable)  state_next = RUN;
      RUN:     if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (enable) begin
      if (cnt == TC) begin
        timer_out_next = 1'b1;
      end else begin
        cnt_next = cnt + ONE;
      end
    end
  end

`ifdef TIMEOUT_TIMER_STATUS_EN
  assign count_out = cnt;
  assign running   = (state == RUN);
`endif

endmodule

// File: tb/tb_timeout_timer.sv
// Randomised self-checking bench for timeout_timer against a run-length model;
// covers TIMEOUT_TIMER_STATUS_EN outputs when that macro is defined.
module tb_timeout_timer;

  localparam int W      = 4;
  localparam int PERIOD = 16;
  localparam int P1     = 2;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic enable1;
  logic timer_out;
  logic timer_out1;
`ifdef TIMEOUT_TIMER_STATUS_EN
  logic [W-1:0] count_out, count_out1;
  logic         running, running1;
`endif

  int checks = 0;
  int errors = 0;

  // Model: number of consecutive enabled edges since the last clear.
  int run_len  = 0;
  int run_len1 = 0;
  bit exp_out  = 1'b0;
  bit exp_out1 = 1'b0;
  bit exp_run  = 1'b0;
  bit exp_run1 = 1'b0;

  always #5 clk = ~clk;

  timeout_timer #(.TIMER_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .timer_out(timer_out)
`ifdef TIMEOUT_TIMER_STATUS_EN
    , .count_out(count_out), .running(running)
`endif
  );

  timeout_timer #(.TIMER_WIDTH(W), .TERMINAL_COUNT(1)) dut_tc1 (
    .clk(clk), .reset(reset), .enable(enable1), .timer_out(timer_out1)
`ifdef TIMEOUT_TIMER_STATUS_EN
    , .count_out(count_out1), .running(running1)
`endif
  );

  task automatic step();
    bit r, e, e1;
    r  = reset;
    e  = enable;
    e1 = enable1;
    @(posedge clk);
    if (r || !e) begin
      run_len = 0;
      exp_out = 1'b0;
    end else begin
      run_len = run_len + 1;
      exp_out = (run_len % PERIOD) == 0;
    end
    if (r || !e1) begin
      run_len1 = 0;
      exp_out1 = 1'b0;
    end else begin
      run_len1 = run_len1 + 1;
      exp_out1 = (run_len1 % P1) == 0;
    end
    exp_run  = !r && e;
    exp_run1 = !r && e1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; enable1 = 1'b1;
    step(); step();
    checks++;
    if (timer_out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out: got %b want 0", timer_out);
    end
    checks++;
    if (timer_out1 !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_tc1: got %b want 0", timer_out1);
    end
`ifdef TIMEOUT_TIMER_STATUS_EN
    checks++;
    if (count_out !== '0 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status: count %0d running %b want 0/0", count_out, running);
    end
`endif
    enable = 1'b0; enable1 = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_first_pulse();
    enable = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      step();
      checks++;
      if (timer_out !== (e == 16)) begin
        errors++; $display("[TB] FAIL first_pulse edge %0d: got %b want %b", e, timer_out, (e == 16));
      end
`ifdef TIMEOUT_TIMER_STATUS_EN
      checks++;
      if (count_out !== W'(e % PERIOD) || running !== 1'b1) begin
        errors++;
        $display("[TB] FAIL status_track edge %0d: count %0d running %b want %0d/1", e, count_out, running, e % PERIOD);
      end
`endif
    end
    enable = 1'b0;
    step();
`ifdef TIMEOUT_TIMER_STATUS_EN
    checks++;
    if (running !== 1'b0 || count_out !== '0) begin
      errors++; $display("[TB] FAIL status_fall: count %0d running %b want 0/0", count_out, running);
    end
`endif
  endtask

  task automatic test_auto_reload();
    int pulses;
    int bad_pos;
    pulses = 0; bad_pos = 0;
    enable = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (timer_out === 1'b1) begin
        pulses++;
        if (c % 16 != 0) bad_pos++;
      end
    end
    checks++;
    if (pulses != 3 || bad_pos != 0) begin
      errors++; $display("[TB] FAIL auto_reload: pulses %0d misplaced %0d want 3/0", pulses, bad_pos);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_disable_mid();
    int first;
    enable = 1'b1;
    for (int c = 0; c < 10; c++) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (timer_out === 1'b1 && first < 0) first = c;
    end
    checks++;
    if (first != 16) begin
      errors++; $display("[TB] FAIL disable_mid: first pulse at %0d want 16", first);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int first;
    enable = 1'b1;
    for (int c = 0; c < 12; c++) step();
    reset = 1'b1;
    step();
    checks++;
    if (timer_out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_out: got %b want 0", timer_out);
    end
`ifdef TIMEOUT_TIMER_STATUS_EN
    checks++;
    if (count_out !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_count: got %0d want 0", count_out);
    end
`endif
    reset = 1'b0;
    first = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (timer_out === 1'b1 && first < 0) first = c;
    end
    checks++;
    if (first != 16) begin
      errors++; $display("[TB] FAIL reset_mid: first pulse at %0d want 16", first);
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_tc1();
    enable1 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (timer_out1 !== (e % 2 == 0)) begin
        errors++; $display("[TB] FAIL tc1_toggle edge %0d: got %b want %b", e, timer_out1, (e % 2 == 0));
      end
    end
    enable1 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (timer_out1 !== 1'b0) begin
        errors++; $display("[TB] FAIL tc1_drop edge %0d: got %b want 0", e, timer_out1);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset   = ($urandom_range(0, 99) < 3);
      enable  = ($urandom_range(0, 99) < 92);
      enable1 = ($urandom_range(0, 99) < 70);
      step();
      checks++;
      if (timer_out !== exp_out || timer_out1 !== exp_out1) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: out %b/%b want %b/%b", c, timer_out, timer_out1, exp_out, exp_out1);
      end
`ifdef TIMEOUT_TIMER_STATUS_EN
      checks++;
      if (count_out !== W'(run_len % PERIOD) || running !== exp_run ||
          count_out1 !== W'(run_len1 % P1) || running1 !== exp_run1) begin
        errors++;
        $display("[TB] FAIL random_status cycle %0d: count %0d run %b want %0d/%b", c, count_out, running,
                 run_len % PERIOD, exp_run);
      end
`endif
    end
    reset = 1'b0; enable = 1'b0; enable1 = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; enable1 = 1'b0;
    #2;
    test_reset();
    test_first_pulse();
    test_auto_reload();
    test_disable_mid();
    test_reset_mid();
    test_tc1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
